// File: rtl/playfield_lock_clear.sv
// playfield_lock_clear: parametrised Tetris playfield store.
// Accepts 4-cell piece locks, clears full rows one row move per cycle,
// scores the clear, serves a registered pixel read port and a
// combinational collision probe.
// Optional build macro: SCORE_TABLE_EN selects the classic 40/100/300/1200
// score table; when undefined each cleared line scores 1.
//
// state  | meaning
// IDLE   | waiting for a piece lock
// LOCK   | write the latched piece cells into the grid
// SCAN   | test row r for full, walking from the bottom up
// SHIFT  | move rows above p down by one, one row per cycle
// DONE   | add score, publish lines_cleared, pulse clear_done
module playfield_lock_clear #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int COLOR_W = 3,
  parameter int SCORE_W = 16,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lock_valid,
  output logic               lock_ready,
  input  logic [4*XW-1:0]    lock_x,
  input  logic [4*YW-1:0]    lock_y,
  input  logic [COLOR_W-1:0] lock_color,
  input  logic [4*XW-1:0]    probe_x,
  input  logic [4*YW-1:0]    probe_y,
  output logic               probe_hit,
  input  logic [XW-1:0]      rd_x,
  input  logic [YW-1:0]      rd_y,
  output logic [COLOR_W-1:0] rd_color,
  output logic               busy,
  output logic               clear_done,
  output logic [2:0]         lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOCK  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [XW:0]   COLS_L   = (XW+1)'(COLS);
  localparam logic [YW:0]   ROWS_L   = (YW+1)'(ROWS);
  localparam logic [YW-1:0] ROW_LAST = YW'(ROWS-1);
  // Sum is wide enough for the largest table entry on top of a full score.
  localparam int SUMW = ((SCORE_W > 11) ? SCORE_W : 11) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [COLOR_W-1:0] grid [ROWS][COLS];
  logic [2:0]         state;
  logic [4*XW-1:0]    lx_q;
  logic [4*YW-1:0]    ly_q;
  logic [COLOR_W-1:0] lcol_q;
  logic [YW-1:0]      r_ptr;
  logic [YW-1:0]      p_ptr;
  logic [2:0]         n_cnt;
  logic               accept;
  logic               row_full;
  logic               lock_top;
  logic [SUMW-1:0]    score_sum;
  logic [SCORE_W-1:0] score_next;

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ({1'b0, x} < COLS_L) && ({1'b0, y} < ROWS_L);
  endfunction

  // n above 4 cannot happen with 4-cell pieces; it is clamped to 4 anyway.
  function automatic logic [10:0] line_score(input logic [2:0] n);
    logic [2:0] nc;
    nc = (n > 3'd4) ? 3'd4 : n;
`ifdef SCORE_TABLE_EN
    case (nc)
      3'd1:    return 11'd40;
      3'd2:    return 11'd100;
      3'd3:    return 11'd300;
      3'd4:    return 11'd1200;
      default: return 11'd0;
    endcase
`else
    return 11'(nc);
`endif
  endfunction

  assign lock_ready = (state == S_IDLE) && !game_over;
  assign busy       = (state != S_IDLE);
  assign clear_done = (state == S_DONE);
  assign accept     = lock_valid && lock_ready;

  assign score_sum  = SUMW'(score) + SUMW'(line_score(n_cnt));
  assign score_next = (score_sum > SUMW'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  // Row under the scan pointer is full when every cell is nonzero.
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (grid[r_ptr][c] == '0) row_full = 1'b0;
    end
  end

  // Any in-range cell of the latched piece landing in the top row ends the game.
  always_comb begin
    lock_top = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (in_range(lx_q[k*XW +: XW], ly_q[k*YW +: YW]) && (ly_q[k*YW +: YW] == '0))
        lock_top = 1'b1;
    end
  end

  // Collision probe: walls and floor hit, occupied cells hit, busy blocks movement.
  always_comb begin
    probe_hit = busy;
    for (int k = 0; k < 4; k++) begin
      if (!in_range(probe_x[k*XW +: XW], probe_y[k*YW +: YW]))
        probe_hit = 1'b1;
      else if (grid[probe_y[k*YW +: YW]][probe_x[k*XW +: XW]] != '0)
        probe_hit = 1'b1;
    end
  end

  // Sequencer and grid storage: lock write, bottom-up scan, row shifting, scoring.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      lx_q          <= '0;
      ly_q          <= '0;
      lcol_q        <= '0;
      r_ptr         <= '0;
      p_ptr         <= '0;
      n_cnt         <= '0;
      lines_cleared <= '0;
      score         <= '0;
      game_over     <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          grid[r][c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lx_q   <= lock_x;
            ly_q   <= lock_y;
            lcol_q <= lock_color;
            state  <= S_LOCK;
          end
        end
        S_LOCK: begin
          for (int k = 0; k < 4; k++) begin
            if (in_range(lx_q[k*XW +: XW], ly_q[k*YW +: YW]))
              grid[ly_q[k*YW +: YW]][lx_q[k*XW +: XW]] <= lcol_q;
          end
          if (lock_top) game_over <= 1'b1;
          r_ptr <= ROW_LAST;
          n_cnt <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (row_full) begin
            n_cnt <= n_cnt + 3'd1;
            p_ptr <= r_ptr;
            state <= S_SHIFT;
          end else if (r_ptr == '0) begin
            lines_cleared <= n_cnt;
            state         <= S_DONE;
          end else begin
            r_ptr <= r_ptr - YW'(1);
          end
        end
        S_SHIFT: begin
          // r_ptr is left alone so the row that dropped into it gets rescanned.
          if (p_ptr != '0) begin
            for (int c = 0; c < COLS; c++)
              grid[p_ptr][c] <= grid[p_ptr - YW'(1)][c];
            p_ptr <= p_ptr - YW'(1);
          end else begin
            for (int c = 0; c < COLS; c++)
              grid[0][c] <= '0;
            state <= S_SCAN;
          end
        end
        S_DONE: begin
          score <= score_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered pixel read; live during clears so the shifting is visible.
  always_ff @(posedge clk) begin
    if (reset)
      rd_color <= '0;
    else if (in_range(rd_x, rd_y))
      rd_color <= grid[rd_y][rd_x];
    else
      rd_color <= '0;
  end

endmodule
